spi_reg_slave: RTL

Serial-to-parallel front end for the GPIO register bank. Receives 16-bit SPI frames from the host controller, synchronizes them into the system clock domain, and issues a one-cycle strobe with a 7-bit address and 8-bit data. Every per-address register in the bank is fed from this strobe. An optional readback path shifts register contents out on SDO.

---
 rtl/spi_reg_slave.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_reg_slave.sv
// spi_reg_slave
// SPI-to-register-bank front end. Receives 16-bit frames (R/W, 7-bit address,
// 8-bit data; MSB first). Synchronizes them into the CLK domain and issues a
// one-cycle write strobe with address and data. An optional readback path
// shifts RD_DATA out on SDO during the data phase of a read frame.
//
// Build option: define SPI_READBACK_EN to enable the readback path.
// Without it, RD_STB and SDO are tied low and RD_DATA is ignored.
//
// Parameters:
//   SYNC_STAGES  depth of the SCLK/SEN/SDI synchronizers (>= 2)
// Ports:
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   SCLK     in   SPI clock (idle low); SDI sampled on its rising edge
//   SEN      in   SPI enable, active low
//   SDI      in   serial data in, MSB first
//   SDO      out  serial readback data
//   RD_DATA  in   readback value for ADDR, captured while RD_STB is high
//   RD_STB   out  one-cycle readback capture pulse
//   STB      out  one-cycle write strobe
//   ADDR     out  register address of the current/last frame
//   DATA     out  write data of the last completed write frame
module spi_reg_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SCLK,
  input  logic       SEN,
  input  logic       SDI,
  output logic       SDO,
  input  logic [7:0] RD_DATA,
  output logic       RD_STB,
  output logic       STB,
  output logic [6:0] ADDR,
  output logic [7:0] DATA
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE, S_WAIT} state_t;

  // All three pins go through identical synchronizer chains so their
  // relative timing is preserved in the CLK domain.
  logic [SYNC_STAGES-1:0] sclk_sync_reg, sen_sync_reg, sdi_sync_reg;
  logic                   sclk_s, sen_s, sdi_s;
  logic                   sclk_prev_reg, rise_reg, fall_reg;

  state_t      state_reg, state_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic [15:0] shift_reg, shift_next;
  logic [7:0]  sdo_shift_reg, sdo_shift_next;
  logic [6:0]  addr_reg, addr_next;
  logic [7:0]  data_reg, data_next;
  logic        stb_reg, stb_next;
  logic        rd_stb_reg, rd_stb_next;
  // Cleared by reset, set once SEN is seen high. Keeps a frame that was
  // already in progress at reset release from being decoded.
  logic        armed_reg;

  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign sen_s  = sen_sync_reg[SYNC_STAGES-1];
  assign sdi_s  = sdi_sync_reg[SYNC_STAGES-1];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_sync_reg <= '0;
      sen_sync_reg  <= '0;
      sdi_sync_reg  <= '0;
      sclk_prev_reg <= 1'b0;
      rise_reg      <= 1'b0;
      fall_reg      <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
      sen_sync_reg  <= {sen_sync_reg[SYNC_STAGES-2:0], SEN};
      sdi_sync_reg  <= {sdi_sync_reg[SYNC_STAGES-2:0], SDI};
      sclk_prev_reg <= sclk_s;
      // Registered edge pulses: SYNC_STAGES+1 CLK after the pin edge.
      rise_reg      <= sclk_s & ~sclk_prev_reg;
      fall_reg      <= ~sclk_s & sclk_prev_reg;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      sdo_shift_reg <= '0;
      addr_reg      <= '0;
      data_reg      <= '0;
      stb_reg       <= 1'b0;
      rd_stb_reg    <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      sdo_shift_reg <= sdo_shift_next;
      addr_reg      <= addr_next;
      data_reg      <= data_next;
      stb_reg       <= stb_next;
      rd_stb_reg    <= rd_stb_next;
      armed_reg     <= armed_reg | sen_s;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    shift_next     = shift_reg;
    sdo_shift_next = sdo_shift_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    stb_next       = 1'b0;
    rd_stb_next    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next       = '0;
        shift_next     = '0;
        sdo_shift_next = '0;
        if (armed_reg && !sen_s) state_next = S_SHIFT;
      end

      S_SHIFT: begin
        if (sen_s) begin
          // Frame aborted before 16 bits: drop it without a strobe.
          state_next     = S_IDLE;
          cnt_next       = '0;
          sdo_shift_next = '0;
        end else begin
          if (rise_reg) begin
            shift_next = {shift_reg[14:0], sdi_s};
            cnt_next   = cnt_reg + 5'd1;
            if (cnt_next == 5'd8) begin
              // Header complete: shift_next[7] is R/W, [6:0] the address.
              addr_next = shift_next[6:0];
`ifdef SPI_READBACK_EN
              rd_stb_next = shift_next[7];
`endif
            end
            if (cnt_next == 5'd16) begin
              state_next     = S_DONE;
              sdo_shift_next = '0;
              if (!shift_next[15]) begin
                stb_next  = 1'b1;
                addr_next = shift_next[14:8];
                data_next = shift_next[7:0];
              end
            end
          end else if (fall_reg && cnt_reg >= 5'd9 && cnt_reg <= 5'd15) begin
            sdo_shift_next = {sdo_shift_reg[6:0], 1'b0};
          end
`ifdef SPI_READBACK_EN
          if (rd_stb_reg) sdo_shift_next = RD_DATA;
`endif
        end
      end

      S_DONE: state_next = S_WAIT;

      S_WAIT: if (sen_s) state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase
  end

`ifndef SPI_READBACK_EN
  logic unused_rd_data;
  assign unused_rd_data = ^RD_DATA;
`endif

  assign SDO    = sdo_shift_reg[7];
  assign RD_STB = rd_stb_reg;
  assign STB    = stb_reg;
  assign ADDR   = addr_reg;
  assign DATA   = data_reg;

endmodule
